// File: rtl/cordic_engine.sv
// cordic_engine: pipelined CORDIC with a runtime mode per sample (0 = rotation, 1 = vectoring).
// A quadrant pre-rotation stage extends the range to the full circle. Valid/ready flow control
// stalls the whole pipe at once, and a sideband tag travels with each sample.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   in_valid_i/in_ready_o  input handshake; in_ready_o = out_ready_i | ~out_valid_o
//   in_mode_i              0 = rotation (z driven to 0), 1 = vectoring (y driven to 0)
//   in_x_i, in_y_i         signed Q2.(DATA_W-2)
//   in_z_i                 signed Q3.(DATA_W-3) radians, valid range [-pi, +pi]
//   in_tag_i               sideband tag
//   out_valid_o/out_ready_i output handshake
//   out_x_o, out_y_o       rounded, saturated, scaled by the CORDIC gain K
//   out_z_o                rounded residual (rotation) or accumulated (vectoring) angle
//   out_tag_o              tag of the sample on out_*
//   busy_o                 any stage, including the output register, holds a valid sample
module cordic_engine #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ITERATIONS = 14,
    parameter int unsigned GUARD_W    = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_mode_i,
    input  logic [DATA_W-1:0] in_x_i,
    input  logic [DATA_W-1:0] in_y_i,
    input  logic [DATA_W-1:0] in_z_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_x_o,
    output logic [DATA_W-1:0] out_y_o,
    output logic [DATA_W-1:0] out_z_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              busy_o
);

    // One extra MSB on x/y absorbs the CORDIC gain before output saturation.
    localparam int unsigned XW = DATA_W + GUARD_W + 1;
    localparam int unsigned ZW = DATA_W + GUARD_W;
    // Stage P plus one register per micro-rotation.
    localparam int unsigned NS = ITERATIONS + 1;

    localparam real ZScale = 2.0 ** (ZW - 3);
    localparam logic signed [ZW-1:0] HalfPi    = ZW'($rtoi(1.5707963267948966 * ZScale + 0.5));
    localparam logic signed [ZW-1:0] NegHalfPi = -HalfPi;

    localparam logic signed [XW:0] RndX   = (XW + 1)'((2 ** GUARD_W) / 2);
    localparam logic signed [ZW:0] RndZ   = (ZW + 1)'((2 ** GUARD_W) / 2);
    localparam logic signed [XW:0] SatMax = (XW + 1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [XW:0] SatMin = (XW + 1)'(-(2 ** (DATA_W - 1)));

    logic en;

    logic [NS-1:0]         vld_q;
    logic [ITERATIONS-1:0] mode_q;
    logic signed [XW-1:0]  x_q [NS];
    logic signed [XW-1:0]  y_q [NS];
    logic signed [ZW-1:0]  z_q [NS];
    logic [TAG_W-1:0]      tag_q [NS];

    logic signed [XW-1:0]  x_d [NS];
    logic signed [XW-1:0]  y_d [NS];
    logic signed [ZW-1:0]  z_d [NS];
    logic [TAG_W-1:0]      tag_d [NS];

    logic                  out_valid_q;
    logic [DATA_W-1:0]     out_x_q, out_y_q, out_z_q;
    logic [TAG_W-1:0]      out_tag_q;

    logic signed [XW-1:0]  xin, yin, px, py;
    logic signed [ZW-1:0]  zin, pz;

    // A stalled output register freezes every stage, so the pipe never drops a sample.
    assign en         = out_ready_i | ~out_valid_q;
    assign in_ready_o = en;

    assign xin = XW'(signed'(in_x_i)) <<< GUARD_W;
    assign yin = XW'(signed'(in_y_i)) <<< GUARD_W;
    assign zin = ZW'(signed'(in_z_i)) <<< GUARD_W;

    // Stage P: quarter-turn so the remaining angle lies inside the CORDIC convergence range.
    always_comb begin
        px = xin;
        py = yin;
        pz = zin;
        if (!in_mode_i) begin
            if (zin > HalfPi) begin
                px = -yin;
                py = xin;
                pz = zin - HalfPi;
            end else if (zin < NegHalfPi) begin
                px = yin;
                py = -xin;
                pz = zin + HalfPi;
            end
        end else if (xin[XW-1]) begin
            if (!yin[XW-1]) begin
                px = yin;
                py = -xin;
                pz = zin + HalfPi;
            end else begin
                px = -yin;
                py = xin;
                pz = zin - HalfPi;
            end
        end
    end

    assign x_d[0]   = px;
    assign y_d[0]   = py;
    assign z_d[0]   = pz;
    assign tag_d[0] = in_tag_i;

    for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
        localparam logic signed [ZW-1:0] Atan =
            ZW'($rtoi($atan(1.0 / (2.0 ** k)) * ZScale + 0.5));

        logic                 d_pos;
        logic signed [XW-1:0] xs, ys;

        assign d_pos = mode_q[k] ? y_q[k][XW-1] : ~z_q[k][ZW-1];
        assign xs    = x_q[k] >>> k;
        assign ys    = y_q[k] >>> k;

        assign x_d[k+1]   = d_pos ? (x_q[k] - ys) : (x_q[k] + ys);
        assign y_d[k+1]   = d_pos ? (y_q[k] + xs) : (y_q[k] - xs);
        assign z_d[k+1]   = d_pos ? (z_q[k] - Atan) : (z_q[k] + Atan);
        assign tag_d[k+1] = tag_q[k];
    end

    function automatic logic [DATA_W-1:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] r;
        r = ((XW + 1)'(v) + RndX) >>> GUARD_W;
        if (r > SatMax) begin
            r = SatMax;
        end else if (r < SatMin) begin
            r = SatMin;
        end
        return r[DATA_W-1:0];
    endfunction

    // Control and output registers: the only state cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            vld_q       <= {vld_q[NS-2:0], in_valid_i};
            out_valid_q <= vld_q[NS-1];
            out_x_q     <= round_sat(x_q[NS-1]);
            out_y_q     <= round_sat(y_q[NS-1]);
            out_z_q     <= DATA_W'(((ZW + 1)'(z_q[NS-1]) + RndZ) >>> GUARD_W);
            out_tag_q   <= tag_q[NS-1];
        end
    end

    // Datapath registers: qualified by vld_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (en) begin
            mode_q <= {mode_q[ITERATIONS-2:0], in_mode_i};
            for (int s = 0; s < NS; s++) begin
                x_q[s]   <= x_d[s];
                y_q[s]   <= y_d[s];
                z_q[s]   <= z_d[s];
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_x_o     = out_x_q;
    assign out_y_o     = out_y_q;
    assign out_z_o     = out_z_q;
    assign out_tag_o   = out_tag_q;
    assign busy_o      = (|vld_q) | out_valid_q;

endmodule
